// File: rtl/sweep_pkg.sv
// Shared types and constants for the vector sweep controller.
//   sweep_state_t : FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_VEC       : vectors per pass (all combinations of a,b,c,d)
//   VEC_W         : vector width
//   CNT_W         : width of the settle timer, test_count and errors
//   sat_inc       : saturating increment for CNT_W-wide counters
package sweep_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Settle timer: loadable down-counter with a terminal-count flag.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (takes priority over en)
//   load_val     : value to load
//   en           : decrement by one while non-zero
//   tc           : counter has reached zero
module sweep_settle_cnt
  import sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive vector sweep of a 4-input combinational block.
// Drives {a,b,c,d} through 0..15 REPEAT times, holds each vector for
// SETTLE_CYC cycles, then samples y for one cycle and compares it with
// EXP_TABLE[vector]. Reports counts and a pass flag at the end of the run.
//
// Handshake: start is a level request that is only looked at in IDLE, so a
// start held high or raised while busy never disturbs a run in progress.
// done is a single-cycle completion pulse; pass follows one cycle later and
// stays valid until the next accepted start.
//
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : run request
//   y                : output of the block under sweep
//   a, b, c, d       : registered stimulus, a is the MSB of the vector
//   busy             : high in SETTLE and SAMPLE
//   done             : one-cycle pulse while in DONE
//   test_count       : vectors sampled in the current/last run
//   errors           : mismatches in the current/last run (saturating)
//   pass             : last run completed with no mismatches
//   state_dbg        : current FSM state (sweep_state_t encoding)
//   first_fail_vld   : a mismatch has been seen in this run  (errlog build)
//   first_fail_vec   : vector of the first mismatch          (errlog build)
// Build option: define VECTOR_SWEEP_ERRLOG_EN to add the first-fail log.
module vector_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int          SETTLE_CYC = 5,
  parameter int          REPEAT     = 2,
  parameter logic [15:0] EXP_TABLE  = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] errors,
  output logic             pass,
  output logic [1:0]       state_dbg
`ifdef VECTOR_SWEEP_ERRLOG_EN
  ,
  output logic             first_fail_vld,
  output logic [VEC_W-1:0] first_fail_vec
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [3:0]       LAST_PASS   = 4'(REPEAT - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

  sweep_state_t     state;
  logic [VEC_W-1:0] vec;
  logic [3:0]       pass_idx;
  logic             settle_load;
  logic             settle_tc;
  logic             mismatch;

  // The timer is reloaded on every SAMPLE cycle; when that SAMPLE ends the
  // run the reloaded value is simply never used.
  assign settle_load = ((state == IDLE) && start) || (state == SAMPLE);
  assign mismatch    = (y != EXP_TABLE[vec]);

  sweep_settle_cnt u_settle_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (state == SETTLE),
    .tc       (settle_tc)
  );

  // vec is the stimulus register itself; it is forced back to 0 on the way
  // out of a run so the block under sweep sees 4'h0 whenever idle.
  assign {a, b, c, d} = vec;
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vec        <= '0;
      pass_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      test_count <= '0;
      errors     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= '0;
            pass_idx   <= '0;
            test_count <= '0;
            errors     <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_tc) state <= SAMPLE;
        end
        SAMPLE: begin
          test_count <= test_count + 1'b1;
          if (mismatch) errors <= sat_inc(errors);
          if (vec != LAST_VEC) begin
            vec   <= vec + 1'b1;
            state <= SETTLE;
          end else if (pass_idx < LAST_PASS) begin
            vec      <= '0;
            pass_idx <= pass_idx + 1'b1;
            state    <= SETTLE;
          end else begin
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          pass  <= (errors == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VECTOR_SWEEP_ERRLOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if ((state == IDLE) && start) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if ((state == SAMPLE) && mismatch && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_vec <= vec;
    end
  end
`endif

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench for vector_sweep_ctrl (SETTLE_CYC=5, REPEAT=2).
// The block under sweep is the hw2_prob1 function y = ~(b ^ d), whose truth
// table over vector n = {a,b,c,d} is 16'hA5A5. y_mode selects the y source:
//   0 = golden function, 1 = y tied low, 2 = golden inverted on vector 6.
module tb_vector_sweep_ctrl;
  import sweep_pkg::*;

  localparam int          SETTLE_CYC = 5;
  localparam int          REPEAT     = 2;
  localparam logic [15:0] EXP_TABLE  = 16'hA5A5;
  localparam int          VEC_CYC    = SETTLE_CYC + 1;
  localparam int          RUN_CYC    = 16 * REPEAT * VEC_CYC;  // 192

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       y;
  logic       a, b, c, d;
  logic       busy, done, pass;
  logic [7:0] test_count, errors;
  logic [1:0] state_dbg;
`ifdef VECTOR_SWEEP_ERRLOG_EN
  logic       first_fail_vld;
  logic [3:0] first_fail_vec;
`endif

  int y_mode = 0;
  int checks = 0;
  int passed = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- block under sweep ----------------
  always_comb begin
    y = ~(b ^ d);
    case (y_mode)
      1: y = 1'b0;
      2: if ({a, b, c, d} == 4'd6) y = b ^ d;
      default: ;
    endcase
  end

  vector_sweep_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .REPEAT     (REPEAT),
    .EXP_TABLE  (EXP_TABLE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .y          (y),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .busy       (busy),
    .done       (done),
    .test_count (test_count),
    .errors     (errors),
    .pass       (pass),
    .state_dbg  (state_dbg)
`ifdef VECTOR_SWEEP_ERRLOG_EN
    ,
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec)
`endif
  );

  // ---------------- driver tasks ----------------
  // Raises start for exactly one rising edge; returns just after that edge.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Rising edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a, b, c, d, busy, done, pass} !== 7'b0) $display("FAIL reset_bits: got %b, expected 0000000", {a, b, c, d, busy, done, pass});
    else passed++;
    checks++;
    if ({test_count, errors} !== 16'h0) $display("FAIL reset_counts: got %h, expected 0000", {test_count, errors});
    else passed++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state_dbg !== 2'(IDLE) || busy !== 1'b0) $display("FAIL idle_no_start: got state %0d busy %b, expected state 0 busy 0", state_dbg, busy);
    else passed++;
  endtask

  task automatic test_golden();
    int lat;
    y_mode = 0;
    start_pulse();
    wait_done(lat);
    checks++;
    if (lat !== RUN_CYC) $display("FAIL golden_latency: got %0d, expected %0d", lat, RUN_CYC);
    else passed++;
    checks++;
    if (state_dbg !== 2'(DONE) || busy !== 1'b0) $display("FAIL golden_done_state: got state %0d busy %b, expected state 3 busy 0", state_dbg, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL golden_done_pulse: got %b, expected 0", done);
    else passed++;
    checks++;
    if ({test_count, errors, 7'(pass)} !== {8'd32, 8'd0, 7'd1}) $display("FAIL golden_result: got tc %0d err %0d pass %b, expected 32 0 1", test_count, errors, pass);
    else passed++;
    repeat (5) @(negedge clk);
    checks++;
    if ({a, b, c, d} !== 4'h0 || test_count !== 8'd32 || pass !== 1'b1) $display("FAIL idle_hold: got vec %h tc %0d pass %b, expected 0 32 1", {a, b, c, d}, test_count, pass);
    else passed++;
  endtask

  task automatic test_y_zero();
    int lat;
    y_mode = 1;
    start_pulse();
    @(negedge clk);
    checks++;
    if (pass !== 1'b0 || test_count !== 8'd0 || busy !== 1'b1) $display("FAIL start_clears: got pass %b tc %0d busy %b, expected 0 0 1", pass, test_count, busy);
    else passed++;
    wait_done(lat);
    @(negedge clk);
    checks++;
    if ({test_count, errors, 7'(pass)} !== {8'd32, 8'd16, 7'd0}) $display("FAIL yzero_result: got tc %0d err %0d pass %b, expected 32 16 0", test_count, errors, pass);
    else passed++;
    y_mode = 0;
  endtask

  task automatic test_vector_order();
    int bad_vec;
    int bad_busy;
    logic [3:0] exp_vec;
    y_mode = 0;
    bad_vec = 0;
    bad_busy = 0;
    start_pulse();
    for (int k = 0; k < RUN_CYC; k++) begin
      @(negedge clk);
      exp_vec = 4'((k / VEC_CYC) % 16);
      if ({a, b, c, d} !== exp_vec) bad_vec++;
      if (busy !== 1'b1) bad_busy++;
    end
    checks++;
    if (bad_vec !== 0) $display("FAIL vec_order: got %0d bad cycles, expected 0", bad_vec);
    else passed++;
    checks++;
    if (bad_busy !== 0) $display("FAIL busy_in_run: got %0d low cycles, expected 0", bad_busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || {a, b, c, d} !== 4'h0) $display("FAIL order_end: got done %b vec %h, expected 1 0", done, {a, b, c, d});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int dones;
    int busy_low;
    int lat;
    dones = 0;
    busy_low = 0;
    y_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= RUN_CYC; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (k < RUN_CYC && busy !== 1'b1) busy_low++;
    end
    checks++;
    if (dones !== 1) $display("FAIL held_one_done: got %0d pulses, expected 1", dones);
    else passed++;
    checks++;
    if (busy_low !== 0) $display("FAIL held_busy: got %0d low cycles, expected 0", busy_low);
    else passed++;
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'(IDLE)) $display("FAIL held_done_to_idle: got state %0d, expected 0", state_dbg);
    else passed++;
    repeat (300 - (RUN_CYC + 2)) @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat < 0) $display("FAIL held_second_run: got timeout, expected done");
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    y_mode = 0;
    start_pulse();
    for (int k = 0; k <= 50; k++) @(negedge clk);
    checks++;
    if (test_count !== 8'd8) $display("FAIL mid_count: got %0d, expected 8", test_count);
    else passed++;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({a, b, c, d, busy, done, pass, test_count, errors, state_dbg} !== 25'b0) $display("FAIL async_reset: got %h, expected 0", {a, b, c, d, busy, done, pass, test_count, errors, state_dbg});
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    start_pulse();
    wait_done(lat);
    checks++;
    if (lat !== RUN_CYC) $display("FAIL rerun_latency: got %0d, expected %0d", lat, RUN_CYC);
    else passed++;
    @(negedge clk);
    checks++;
    if ({test_count, errors, 7'(pass)} !== {8'd32, 8'd0, 7'd1}) $display("FAIL rerun_result: got tc %0d err %0d pass %b, expected 32 0 1", test_count, errors, pass);
    else passed++;
  endtask

`ifdef VECTOR_SWEEP_ERRLOG_EN
  task automatic test_errlog();
    int lat;
    y_mode = 1;
    start_pulse();
    wait_done(lat);
    @(negedge clk);
    checks++;
    if (first_fail_vld !== 1'b1 || first_fail_vec !== 4'd0) $display("FAIL errlog_yzero: got vld %b vec %0d, expected 1 0", first_fail_vld, first_fail_vec);
    else passed++;
    y_mode = 2;
    start_pulse();
    @(negedge clk);
    checks++;
    if (first_fail_vld !== 1'b0) $display("FAIL errlog_clear: got %b, expected 0", first_fail_vld);
    else passed++;
    wait_done(lat);
    @(negedge clk);
    checks++;
    if (errors !== 8'd2 || pass !== 1'b0) $display("FAIL errlog_errors: got err %0d pass %b, expected 2 0", errors, pass);
    else passed++;
    checks++;
    if (first_fail_vld !== 1'b1 || first_fail_vec !== 4'd6) $display("FAIL errlog_vec: got vld %b vec %0d, expected 1 6", first_fail_vld, first_fail_vec);
    else passed++;
    y_mode = 0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_golden();
    test_y_zero();
    test_vector_order();
    test_start_held();
    test_reset_mid_run();
`ifdef VECTOR_SWEEP_ERRLOG_EN
    test_errlog();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vector_sweep_ctrl.md
VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 5: clock cycles each vector is held before Y is sampled; legal range 1..255.
REQ-002 Parameter REPEAT, default 2: number of full 16-vector passes per run; legal range 1..15.
REQ-003 Parameter EXP_TABLE, default 16'h0000: expected Y per vector; bit n is expected Y for vector n.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request; sampled in IDLE only.
REQ-007 y  input  1  Y output of the combinational block under sweep.
REQ-008 a, b, c, d  output  1 each  registered stimulus to the block under sweep; {a,b,c,d} = vector, a is MSB.
REQ-009 busy  output  1  high in SETTLE and SAMPLE states.
REQ-010 done  output  1  one-cycle pulse at run completion.
REQ-011 test_count  output  8  vectors sampled in the current or last run.
REQ-012 errors  output  8  mismatches in the current or last run, saturating at 255.
REQ-013 pass  output  1  high when done has fired and errors == 0; cleared on start.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE with start=1 SHALL clear vec, pass_idx, test_count, errors and pass, then go to SETTLE with {a,b,c,d}=4'h0.
REQ-016 SETTLE SHALL hold the vector for SETTLE_CYC cycles using a settle counter, then go to SAMPLE.
REQ-017 SAMPLE lasts one cycle: compare y against EXP_TABLE[vec], test_count +1, errors +1 on mismatch (saturating).
REQ-018 After SAMPLE with vec<15: vec +1, go to SETTLE; vec==15 and pass_idx<REPEAT-1: vec wraps to 0, pass_idx +1, go to SETTLE; otherwise go to DONE.
REQ-019 DONE lasts one cycle: assert done, set pass = (errors==0), go to IDLE; start in DONE SHALL be ignored.
REQ-020 Each vector SHALL be driven for SETTLE_CYC+1 cycles; a run takes 16*REPEAT*(SETTLE_CYC+1) cycles from start acceptance to DONE entry.
REQ-021 start while busy SHALL be ignored; a start held high SHALL NOT cause a second run until the FSM has returned to IDLE.
REQ-022 In IDLE, {a,b,c,d} SHALL be 4'h0; test_count, errors and pass SHALL hold their last-run values.

Reset
REQ-023 reset_n low SHALL immediately force IDLE and set a, b, c, d, busy, done, pass, test_count, errors, vec, pass_idx and the settle counter to 0, including mid-run.
REQ-024 After reset is released, the first rising edge SHALL evaluate IDLE.

Configuration
REQ-025 With macro VECTOR_SWEEP_ERRLOG_EN defined, the block SHALL add outputs first_fail_vld (1 bit) and first_fail_vec (4 bits), capturing the vector of the first mismatch in a run; both are cleared on start and on reset.
REQ-026 Without VECTOR_SWEEP_ERRLOG_EN, those ports and their logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 Package sweep_pkg SHALL hold the state enum typedef sweep_state_t, NUM_VEC=16, VEC_W=4 and CNT_W=8.
REQ-028 Sub-module sweep_settle_cnt (loadable down-counter, terminal-count flag) SHALL implement the settle timer; all other logic SHALL reside in vector_sweep_ctrl.

Verification
REQ-029 Golden hw2_prob1 model on y, EXP_TABLE matching, REPEAT=2, SETTLE_CYC=5, start pulse -> done after 192 cycles, test_count=32, errors=0, pass=1.
REQ-030 y tied 0, EXP_TABLE=16'hA5A5 -> test_count=32, errors=16, pass=0.
REQ-031 Vector order check -> {a,b,c,d} steps 0..15 twice, each value held exactly 6 cycles, a is MSB.
REQ-032 start held high for 300 cycles -> exactly one done pulse within the first 193 cycles; busy stays high throughout the run.
REQ-033 reset_n low at cycle 50 of a run -> all outputs 0 asynchronously; a new start then yields test_count=32 with a full fresh result.
REQ-034 VECTOR_SWEEP_ERRLOG_EN defined, y inverted on vector 6 only -> errors=2, first_fail_vld=1, first_fail_vec=6.
